// File: rtl/gate_array_bist.sv
// WIDTH-slice registered 2-input gate array with eight selectable functions
// and a built-in self-test that sweeps all mode/operand vectors against a golden table.

module gate_slice (
    input  logic [2:0] mode,
    input  logic       a,
    input  logic       b,
    output logic       y
);
    always_comb begin
        case (mode)
            3'b000:  y = a & b;
            3'b001:  y = a | b;
            3'b010:  y = ~(a & b);
            3'b011:  y = ~(a | b);
            3'b100:  y = a ^ b;
            3'b101:  y = ~(a ^ b);
            3'b110:  y = ~a;
            default: y = a;
        endcase
    end
endmodule

module gate_array_bist #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             INJ,
    output logic [WIDTH-1:0] Y,
    output logic             VALID,
    input  logic             BIST_START,
    output logic             BIST_BUSY,
    output logic             BIST_DONE,
    output logic             BIST_FAIL,
    output logic [4:0]       BIST_FAIL_IDX
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Expected output per vector v = {mode, a, b}; nibble per mode, bit index {a,b}.
    localparam logic [31:0] GOLDEN = 32'hC396_17E8;

    state_t           state, state_nxt;
    logic [4:0]       cnt;
    logic             drain;
    logic             cmp_vld;
    logic [4:0]       cmp_idx;
    logic             apply, accept, capture, mismatch;
    logic [2:0]       op_mode;
    logic [WIDTH-1:0] op_a, op_b, res, y_nxt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (BIST_START) state_nxt = RUN;
            RUN:     if (drain)      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        BIST_BUSY = (state == RUN);
        apply     = (state == RUN) && !drain;
        accept    = (state == IDLE) && BIST_START;
        capture   = (state == IDLE) && EN && !BIST_START;
    end

    always_comb begin
        if (state == RUN) begin
            op_mode = cnt[4:2];
            op_a    = {WIDTH{cnt[1]}};
            op_b    = {WIDTH{cnt[0]}};
        end else begin
            op_mode = MODE;
            op_a    = A;
            op_b    = B;
        end
    end

    gate_slice u_slice [WIDTH-1:0] (
        .mode (op_mode),
        .a    (op_a),
        .b    (op_b),
        .y    (res)
    );

    always_comb begin
        y_nxt    = res;
        y_nxt[0] = res[0] ^ INJ;
        mismatch = cmp_vld && (Y != {WIDTH{GOLDEN[cmp_idx]}});
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Y     <= '0;
            VALID <= 1'b0;
        end else begin
            VALID <= capture;
            if (capture || apply) Y <= y_nxt;
        end
    end

    // Compare stage trails the applied vector by one cycle; drain covers the final compare.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt     <= '0;
            drain   <= 1'b0;
            cmp_vld <= 1'b0;
            cmp_idx <= '0;
        end else if (accept) begin
            cnt     <= '0;
            drain   <= 1'b0;
            cmp_vld <= 1'b0;
        end else begin
            cmp_vld <= apply;
            if (apply) begin
                cmp_idx <= cnt;
                cnt     <= cnt + 5'd1;
                if (cnt == 5'd31) drain <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            BIST_DONE     <= 1'b0;
            BIST_FAIL     <= 1'b0;
            BIST_FAIL_IDX <= '0;
        end else if (accept) begin
            BIST_DONE     <= 1'b0;
            BIST_FAIL     <= 1'b0;
            BIST_FAIL_IDX <= '0;
        end else begin
            if (state == RUN && drain) BIST_DONE <= 1'b1;
            if (mismatch && !BIST_FAIL) begin
                BIST_FAIL     <= 1'b1;
                BIST_FAIL_IDX <= cmp_idx;
            end
        end
    end
endmodule

// File: tb/tb_gate_array_bist.sv
// Directed bench for gate_array_bist: functional modes, BIST sweep, fault injection, resets.

module tb_gate_array_bist;
    logic       CLK = 1'b0;
    logic       RST_N;
    logic       EN;
    logic [2:0] MODE;
    logic [3:0] A, B;
    logic       INJ;
    logic [3:0] Y;
    logic       VALID;
    logic       BIST_START;
    logic       BIST_BUSY, BIST_DONE, BIST_FAIL;
    logic [4:0] BIST_FAIL_IDX;

    int pass_cnt = 0;
    int total    = 0;

    gate_array_bist #(.WIDTH(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE(MODE), .A(A), .B(B), .INJ(INJ),
        .Y(Y), .VALID(VALID), .BIST_START(BIST_START), .BIST_BUSY(BIST_BUSY),
        .BIST_DONE(BIST_DONE), .BIST_FAIL(BIST_FAIL), .BIST_FAIL_IDX(BIST_FAIL_IDX)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_bist(input bit with_en);
        BIST_START = 1'b1;
        EN         = with_en;
        step();
        BIST_START = 1'b0;
        EN         = 1'b0;
    endtask

    // Counts BUSY-high samples until BUSY drops (bounded); optionally re-pulses START mid-run.
    task automatic count_busy(input int repulse_at, output int busy_n, output bit valid_seen);
        busy_n     = 0;
        valid_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!BIST_BUSY) break;
            busy_n++;
            if (VALID) valid_seen = 1'b1;
            if (busy_n == repulse_at) BIST_START = 1'b1;
            step();
            BIST_START = 1'b0;
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0; EN = 1'b0; MODE = 3'b000; A = '0; B = '0; INJ = 1'b0; BIST_START = 1'b0;
        step(); step();
        @(negedge CLK); RST_N = 1'b1;
        EN = 1'b1; MODE = 3'b011; A = 4'h0; B = 4'h0;
        step();
        EN = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        total++; if (Y !== 4'h0) $display("FAIL reset_y: got %h want 0", Y); else pass_cnt++;
        total++;
        if ({VALID, BIST_BUSY, BIST_DONE, BIST_FAIL, BIST_FAIL_IDX} !== 9'd0)
            $display("FAIL reset_flags: valid=%b busy=%b done=%b fail=%b idx=%0d want all 0",
                     VALID, BIST_BUSY, BIST_DONE, BIST_FAIL, BIST_FAIL_IDX);
        else pass_cnt++;
        @(negedge CLK); RST_N = 1'b1;
    endtask

    task automatic test_functional();
        EN = 1'b1; MODE = 3'b000; A = 4'b1100; B = 4'b1010;
        step();
        total++; if (Y !== 4'b1000 || VALID !== 1'b1) $display("FAIL and: got y=%b v=%b want 1000/1", Y, VALID); else pass_cnt++;
        MODE = 3'b100;
        step();
        total++; if (Y !== 4'b0110 || VALID !== 1'b1) $display("FAIL xor: got y=%b v=%b want 0110/1", Y, VALID); else pass_cnt++;
        EN = 1'b0; MODE = 3'b000;
        step();
        total++; if (Y !== 4'b0110 || VALID !== 1'b0) $display("FAIL hold: got y=%b v=%b want 0110/0", Y, VALID); else pass_cnt++;
    endtask

    task automatic test_unary();
        EN = 1'b1; MODE = 3'b110; A = 4'b0101; B = 4'b1111;
        step();
        total++; if (Y !== 4'b1010) $display("FAIL not_a: got %b want 1010", Y); else pass_cnt++;
        MODE = 3'b011; A = 4'b0000; B = 4'b0000;
        step();
        total++; if (Y !== 4'b1111) $display("FAIL nor: got %b want 1111", Y); else pass_cnt++;
        MODE = 3'b111; A = 4'b1001; B = 4'bxxxx;
        step();
        total++; if (Y !== 4'b1001) $display("FAIL buf_a: got %b want 1001", Y); else pass_cnt++;
        EN = 1'b0; B = 4'b0000;
        step();
    endtask

    task automatic test_clean_bist();
        int  n;
        bit  vs;
        INJ = 1'b0;
        start_bist(1'b0);
        count_busy(0, n, vs);
        total++; if (n !== 33) $display("FAIL clean_busy_len: got %0d want 33", n); else pass_cnt++;
        total++; if (vs !== 1'b0) $display("FAIL clean_valid: got %b want 0", vs); else pass_cnt++;
        total++; if (BIST_DONE !== 1'b1 || BIST_FAIL !== 1'b0) $display("FAIL clean_result: done=%b fail=%b want 1/0", BIST_DONE, BIST_FAIL); else pass_cnt++;
        total++; if (Y !== 4'b1111) $display("FAIL clean_last_y: got %b want 1111", Y); else pass_cnt++;
        step();
        total++; if (BIST_DONE !== 1'b1 || BIST_BUSY !== 1'b0) $display("FAIL done_level: done=%b busy=%b want 1/0", BIST_DONE, BIST_BUSY); else pass_cnt++;
    endtask

    task automatic test_fault_bist();
        int  n;
        bit  vs;
        INJ = 1'b1;
        start_bist(1'b0);
        total++; if (BIST_DONE !== 1'b0) $display("FAIL start_clears_done: got %b want 0", BIST_DONE); else pass_cnt++;
        count_busy(0, n, vs);
        total++; if (n !== 33) $display("FAIL fault_busy_len: got %0d want 33", n); else pass_cnt++;
        total++;
        if (BIST_DONE !== 1'b1 || BIST_FAIL !== 1'b1 || BIST_FAIL_IDX !== 5'd0)
            $display("FAIL fault_result: done=%b fail=%b idx=%0d want 1/1/0", BIST_DONE, BIST_FAIL, BIST_FAIL_IDX);
        else pass_cnt++;
        total++; if (Y !== 4'b1110) $display("FAIL fault_last_y: got %b want 1110", Y); else pass_cnt++;
        step();
        INJ = 1'b0;
        start_bist(1'b0);
        total++; if (BIST_FAIL !== 1'b0) $display("FAIL start_clears_fail: got %b want 0", BIST_FAIL); else pass_cnt++;
        count_busy(0, n, vs);
        total++; if (BIST_DONE !== 1'b1 || BIST_FAIL !== 1'b0) $display("FAIL rerun_result: done=%b fail=%b want 1/0", BIST_DONE, BIST_FAIL); else pass_cnt++;
        step();
    endtask

    task automatic test_start_with_en();
        int  n;
        bit  vs;
        MODE = 3'b111; A = 4'b0101;
        start_bist(1'b1);
        total++; if (VALID !== 1'b0 || BIST_BUSY !== 1'b1) $display("FAIL start_prio: valid=%b busy=%b want 0/1", VALID, BIST_BUSY); else pass_cnt++;
        EN = 1'b1;
        count_busy(0, n, vs);
        EN = 1'b0;
        total++; if (n !== 33 || vs !== 1'b0) $display("FAIL start_en_run: busy=%0d valid_seen=%b want 33/0", n, vs); else pass_cnt++;
        step();
        step();
    endtask

    task automatic test_restart_ignored();
        int  n;
        bit  vs;
        start_bist(1'b0);
        count_busy(5, n, vs);
        total++; if (n !== 33) $display("FAIL restart_ignored: busy=%0d want 33", n); else pass_cnt++;
        total++; if (BIST_DONE !== 1'b1) $display("FAIL restart_done: got %b want 1", BIST_DONE); else pass_cnt++;
        step();
        step();
    endtask

    task automatic test_reset_mid_run();
        int  n;
        bit  vs;
        INJ = 1'b1;
        start_bist(1'b0);
        for (int i = 0; i < 10; i++) step();
        #2 RST_N = 1'b0;
        #1;
        total++;
        if ({Y, VALID, BIST_BUSY, BIST_DONE, BIST_FAIL, BIST_FAIL_IDX} !== 13'd0)
            $display("FAIL midrun_reset: y=%b busy=%b done=%b fail=%b idx=%0d want all 0",
                     Y, BIST_BUSY, BIST_DONE, BIST_FAIL, BIST_FAIL_IDX);
        else pass_cnt++;
        @(negedge CLK); RST_N = 1'b1; INJ = 1'b0;
        step();
        total++; if (BIST_BUSY !== 1'b0) $display("FAIL midrun_idle: busy=%b want 0", BIST_BUSY); else pass_cnt++;
        start_bist(1'b0);
        count_busy(0, n, vs);
        total++;
        if (n !== 33 || BIST_DONE !== 1'b1 || BIST_FAIL !== 1'b0)
            $display("FAIL after_reset_run: busy=%0d done=%b fail=%b want 33/1/0", n, BIST_DONE, BIST_FAIL);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_functional();
        test_unary();
        test_clean_bist();
        test_fault_bist();
        test_start_with_en();
        test_restart_ignored();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/gate_array_bist.md
Name: gate_array_bist

Overview:
- Parametrised, registered successor to the quad 2-input gate block.
- WIDTH independent 2-input gate slices share one MODE select covering eight logic functions; the output is registered and qualified by VALID.
- Adds a built-in self-test (BIST) FSM. It sweeps every mode and input combination and compares the results against an independent golden truth table.
- Used as the lab's generic gate-array core, replacing the fixed-function gate chips.

Parameters:
WIDTH, 4, number of gate slices (bits of A, B, Y); legal range 1..32

Ports:
CLK  in  1  rising-edge clock
RST_N  in  1  asynchronous active-low reset
EN  in  1  capture enable for functional path
MODE  in  3  gate function select
A  in  WIDTH  operand A
B  in  WIDTH  operand B
INJ  in  1  fault injection; inverts slice-0 result (functional and BIST paths)
Y  out  WIDTH  registered gate result
VALID  out  1  Y updated by functional capture this cycle
BIST_START  in  1  single-cycle start request
BIST_BUSY  out  1  self-test running
BIST_DONE  out  1  self-test finished; level, cleared on next accepted start
BIST_FAIL  out  1  sticky mismatch flag; cleared on next accepted start
BIST_FAIL_IDX  out  5  vector index of first mismatch

Behaviour:
- Reset (RST_N=0, asynchronous):
  - Y=0, VALID=0, BIST_BUSY=0, BIST_DONE=0, BIST_FAIL=0, BIST_FAIL_IDX=0.
  - FSM returns to IDLE and the vector counter returns to 0.
- MODE encoding, bitwise per slice:
  - 000 AND, 001 OR, 010 NAND, 011 NOR
  - 100 XOR, 101 XNOR, 110 NOT A (B ignored), 111 BUF A (B ignored)
- Fault injection: result bit 0 is XORed with INJ before the Y register.
- Functional path (FSM in IDLE):
  - EN=1: Y <= f(MODE,A,B) at the next edge; VALID=1 for that cycle. Latency is 1 cycle.
  - EN=0: Y holds its value; VALID=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when BIST_START=1.
  - BIST_START has priority over EN in the same cycle; no functional capture occurs in that cycle.
  - Accepting a start clears BIST_DONE, BIST_FAIL and BIST_FAIL_IDX.
  - BIST_BUSY=1 from the edge after the start for exactly 33 cycles.
- RUN vector sequencing:
  - 5-bit counter v = 0..31, one vector per cycle.
  - Vector fields: mode=v[4:2], a=v[1], b=v[0].
  - Internal operands: A_int={WIDTH{a}}, B_int={WIDTH{b}}. They drive the same gate logic and the same Y register.
  - Pipelined compare: in the cycle after vector v is applied, every bit of Y is compared against golden[v].
  - golden is a 32-bit constant truth table, written independently of the gate logic.
  - On the first mismatch: BIST_FAIL<=1, BIST_FAIL_IDX<=v.
  - Later mismatches do not overwrite BIST_FAIL_IDX.
- RUN -> DONE after the compare of v=31:
  - BIST_BUSY falls and BIST_DONE rises on the same edge.
  - DONE -> IDLE on the following cycle. BIST_DONE stays high.
- During RUN:
  - EN, A, B and MODE are ignored; VALID=0.
  - Y shows the internal test results.
  - BIST_START is ignored; the sweep does not restart.
- Counter: 5-bit; the wrap from 31 to 0 is terminal, not a restart.
- Reset mid-RUN aborts immediately to the reset values. No partial DONE or FAIL remains.
- In DONE or IDLE after a test, Y holds the last test value until the next EN capture.

Test Plan:
- Reset check: RST_N=0 asynchronously mid-cycle -> Y=0000, VALID=0, BIST_BUSY/DONE/FAIL=0, BIST_FAIL_IDX=0 immediately, without waiting for a clock edge.
- Functional AND/XOR with WIDTH=4:
  - EN=1, MODE=000, A=1100, B=1010 -> next edge Y=1000, VALID=1.
  - Then MODE=100 -> Y=0110.
  - Then EN=0 -> Y stays 0110, VALID=0.
- Unary and inverted modes:
  - MODE=110, A=0101 -> Y=1010.
  - MODE=011, A=0000, B=0000 -> Y=1111.
  - MODE=111, A=1001, B=xxxx -> Y=1001.
- Clean BIST: INJ=0, one-cycle BIST_START -> BIST_BUSY high exactly 33 cycles, then BIST_DONE=1, BIST_FAIL=0, VALID=0 throughout the run.
- Fault BIST:
  - INJ=1, BIST_START -> BIST_DONE=1, BIST_FAIL=1, BIST_FAIL_IDX=0 (AND, a=0, b=0 expects 0; Y[0]=1).
  - Rerun with INJ=0 -> BIST_FAIL cleared to 0.
- Boundary cases:
  - BIST_START and EN=1 in the same IDLE cycle -> BIST runs and VALID stays 0.
  - BIST_START re-pulsed at RUN cycle 5 -> ignored; BUSY still lasts 33 cycles.
  - RST_N=0 at RUN cycle 10 -> all outputs cleared; the next start completes normally.
